// File: rtl/mem_responder.sv
// Dual-port memory responder: read-only instruction port and read/write data port
// with byte-lane write masks. Each port serves one request at a time with a fixed latency.
module mem_responder #(
   parameter int unsigned DEPTH     = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned ILATENCY  = 1,
   parameter int unsigned DLATENCY  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] imem_addr,
   input  logic [3:0]  imem_rmask,
   output logic [31:0] imem_rdata,
   output logic        imem_resp,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic        err
);

   localparam int AW  = $clog2(DEPTH);
   localparam int ICW = $clog2(ILATENCY + 1);
   localparam int DCW = $clog2(DLATENCY + 1);
   localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] mask);
      logic [31:0] res;
      res = old;
      for (int b = 0; b < 4; b++)
         if (mask[b]) res[8*b +: 8] = data[8*b +: 8];
      return res;
   endfunction

   logic [31:0] mem [DEPTH];

   state_t          istate, dstate;
   logic [ICW-1:0]  icnt;
   logic [DCW-1:0]  dcnt;
   logic [AW-1:0]   iidx, didx;
   logic            iok, dok, dboth;
   logic [3:0]      dwmask_q;
   logic [31:0]     dwdata_q;

   // Offsets are unsigned, so addresses below BASE_ADDR wrap high and fail the range test.
   logic [31:0] i_off, d_off;
   logic        i_ok_in, d_ok_in;
   logic [AW-1:0] i_idx_in, d_idx_in;
   assign i_off    = imem_addr - BASE_ADDR;
   assign d_off    = dmem_addr - BASE_ADDR;
   assign i_ok_in  = {1'b0, i_off} < LIMIT;
   assign d_ok_in  = {1'b0, d_off} < LIMIT;
   assign i_idx_in = i_off[AW+1:2];
   assign d_idx_in = d_off[AW+1:2];

   logic          i_req, d_req, wr_commit;
   logic [AW-1:0] i_sel_idx, d_sel_idx;
   logic          i_sel_ok, d_sel_ok;
   logic [31:0]   i_raw, i_word, d_word;
   assign i_req     = imem_rmask != 4'h0;
   assign d_req     = (dmem_rmask != 4'h0) || (dmem_wmask != 4'h0);
   assign wr_commit = (dstate == RESP) && dok && (dwmask_q != 4'h0);
   assign i_sel_idx = (istate == IDLE) ? i_idx_in : iidx;
   assign i_sel_ok  = (istate == IDLE) ? i_ok_in : iok;
   assign d_sel_idx = (dstate == IDLE) ? d_idx_in : didx;
   assign d_sel_ok  = (dstate == IDLE) ? d_ok_in : dok;
   assign i_raw     = mem[i_sel_idx];
   // A write committing on the edge imem enters RESP is already visible to that response.
   assign i_word    = !i_sel_ok ? 32'h0 :
                      (wr_commit && didx == i_sel_idx) ? merge(i_raw, dwdata_q, dwmask_q) : i_raw;
   assign d_word    = d_sel_ok ? mem[d_sel_idx] : 32'h0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         istate     <= IDLE;
         imem_resp  <= 1'b0;
         imem_rdata <= 32'h0;
         icnt       <= '0;
         iidx       <= '0;
         iok        <= 1'b0;
      end else begin
         imem_resp <= 1'b0;
         case (istate)
            IDLE: if (i_req) begin
               iidx <= i_idx_in;
               iok  <= i_ok_in;
               icnt <= ICW'(ILATENCY - 1);
               if (ILATENCY == 1) begin
                  istate     <= RESP;
                  imem_resp  <= 1'b1;
                  imem_rdata <= i_word;
               end else begin
                  istate <= WAIT;
               end
            end
            WAIT: begin
               icnt <= icnt - ICW'(1);
               if (icnt == ICW'(1)) begin
                  istate     <= RESP;
                  imem_resp  <= 1'b1;
                  imem_rdata <= i_word;
               end
            end
            default: istate <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         dstate     <= IDLE;
         dmem_resp  <= 1'b0;
         dmem_rdata <= 32'h0;
         dcnt       <= '0;
         didx       <= '0;
         dok        <= 1'b0;
         dboth      <= 1'b0;
         dwmask_q   <= 4'h0;
         dwdata_q   <= 32'h0;
      end else begin
         dmem_resp <= 1'b0;
         case (dstate)
            IDLE: if (d_req) begin
               didx     <= d_idx_in;
               dok      <= d_ok_in;
               dboth    <= (dmem_rmask != 4'h0) && (dmem_wmask != 4'h0);
               dwmask_q <= dmem_wmask;
               dwdata_q <= dmem_wdata;
               dcnt     <= DCW'(DLATENCY - 1);
               if (DLATENCY == 1) begin
                  dstate     <= RESP;
                  dmem_resp  <= 1'b1;
                  dmem_rdata <= d_word;
               end else begin
                  dstate <= WAIT;
               end
            end
            WAIT: begin
               dcnt <= dcnt - DCW'(1);
               if (dcnt == DCW'(1)) begin
                  dstate     <= RESP;
                  dmem_resp  <= 1'b1;
                  dmem_rdata <= d_word;
               end
            end
            default: dstate <= IDLE;
         endcase
      end
   end

   // Writes land on the edge that ends RESP, so any read registered earlier sees old data.
   always_ff @(posedge clk) begin
      if (rst && wr_commit)
         mem[didx] <= merge(mem[didx], dwdata_q, dwmask_q);
   end

   always_ff @(posedge clk) begin
      if (!rst)
         err <= 1'b0;
      else if ((istate == RESP && !iok) || (dstate == RESP && (!dok || dboth)))
         err <= 1'b1;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances cover DLATENCY 2, 1 and 3,
// with a dmem vector table plus hand-written imem, collision and reset sequences.
module tb_mem_responder;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] ia[3], ird[3], da[3], dwd[3], drd[3];
   logic [3:0]  irm[3], drm[3], dwm[3];
   logic        irs[3], drs[3], er[3];

   mem_responder #(.DEPTH(4096), .BASE_ADDR(32'h0), .ILATENCY(1), .DLATENCY(2)) u_a (
      .clk(clk), .rst(rst), .imem_addr(ia[0]), .imem_rmask(irm[0]), .imem_rdata(ird[0]),
      .imem_resp(irs[0]), .dmem_addr(da[0]), .dmem_rmask(drm[0]), .dmem_wmask(dwm[0]),
      .dmem_wdata(dwd[0]), .dmem_rdata(drd[0]), .dmem_resp(drs[0]), .err(er[0]));
   mem_responder #(.DEPTH(16), .BASE_ADDR(32'h100), .ILATENCY(1), .DLATENCY(1)) u_b (
      .clk(clk), .rst(rst), .imem_addr(ia[1]), .imem_rmask(irm[1]), .imem_rdata(ird[1]),
      .imem_resp(irs[1]), .dmem_addr(da[1]), .dmem_rmask(drm[1]), .dmem_wmask(dwm[1]),
      .dmem_wdata(dwd[1]), .dmem_rdata(drd[1]), .dmem_resp(drs[1]), .err(er[1]));
   mem_responder #(.DEPTH(16), .BASE_ADDR(32'h100), .ILATENCY(1), .DLATENCY(3)) u_c (
      .clk(clk), .rst(rst), .imem_addr(ia[2]), .imem_rmask(irm[2]), .imem_rdata(ird[2]),
      .imem_resp(irs[2]), .dmem_addr(da[2]), .dmem_rmask(drm[2]), .dmem_wmask(dwm[2]),
      .dmem_wdata(dwd[2]), .dmem_rdata(drd[2]), .dmem_resp(drs[2]), .err(er[2]));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one dmem request, wait (bounded) for the response, then sample err one cycle later.
   task automatic dmem_txn(input int u, input logic [31:0] addr, input logic [3:0] rm,
                           input logic [3:0] wm, input logic [31:0] wd, input int lat_exp,
                           output logic [31:0] rdata, output logic err_after);
      int  n;
      logic seen;
      @(negedge clk);
      da[u] = addr; drm[u] = rm; dwm[u] = wm; dwd[u] = wd;
      @(posedge clk);
      @(negedge clk);
      drm[u] = 4'h0; dwm[u] = 4'h0;
      n = 1;
      seen = drs[u];
      while (!seen && n < 10) begin
         @(negedge clk);
         n++;
         seen = drs[u];
      end
      chk("dmem_latency", 32'(n), 32'(lat_exp));
      rdata = drd[u];
      @(negedge clk);
      chk("dmem_resp_single_pulse", {31'h0, drs[u]}, 32'h0);
      err_after = er[u];
   endtask

   typedef struct {
      logic        pre_rst;
      logic [31:0] addr;
      logic [3:0]  rm;
      logic [3:0]  wm;
      logic [31:0] wd;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl[15];

   initial begin
      logic [31:0] rd;
      logic        e;
      logic        seen;

      tbl[0]  = '{1'b0, 32'h0000_0008, 4'h0, 4'b0110, 32'h00AB_CD00, 1'b0, 32'h0,          1'b0};
      tbl[1]  = '{1'b0, 32'h0000_0008, 4'hF, 4'h0,    32'h0,         1'b1, 32'h11AB_CD44, 1'b0};
      tbl[2]  = '{1'b0, 32'h0000_000C, 4'h1, 4'h0,    32'h0,         1'b1, 32'hCAFE_F00D, 1'b0};
      tbl[3]  = '{1'b0, 32'h0000_000C, 4'h0, 4'b1001, 32'hAA00_00BB, 1'b0, 32'h0,          1'b0};
      tbl[4]  = '{1'b0, 32'h0000_000C, 4'h2, 4'h0,    32'h0,         1'b1, 32'hAAFE_F0BB, 1'b0};
      tbl[5]  = '{1'b0, 32'h0000_001C, 4'h0, 4'hF,    32'h1234_5678, 1'b0, 32'h0,          1'b0};
      tbl[6]  = '{1'b0, 32'h0000_001F, 4'h4, 4'h0,    32'h0,         1'b1, 32'h1234_5678, 1'b0};
      tbl[7]  = '{1'b0, 32'h0000_3FFC, 4'h0, 4'hF,    32'h5A5A_5A5A, 1'b0, 32'h0,          1'b0};
      tbl[8]  = '{1'b0, 32'h0000_3FFE, 4'hF, 4'h0,    32'h0,         1'b1, 32'h5A5A_5A5A, 1'b0};
      tbl[9]  = '{1'b0, 32'h0000_0020, 4'hF, 4'hF,    32'h1357_9BDF, 1'b1, 32'h0BAD_F00D, 1'b1};
      tbl[10] = '{1'b0, 32'h0000_0020, 4'hF, 4'h0,    32'h0,         1'b1, 32'h1357_9BDF, 1'b1};
      tbl[11] = '{1'b1, 32'h0000_4000, 4'hF, 4'h0,    32'h0,         1'b1, 32'h0,          1'b1};
      tbl[12] = '{1'b0, 32'hFFFF_FFFC, 4'h0, 4'hF,    32'hFFFF_FFFF, 1'b1, 32'h0,          1'b1};
      tbl[13] = '{1'b0, 32'h0000_3FFC, 4'hF, 4'h0,    32'h0,         1'b1, 32'h5A5A_5A5A, 1'b1};
      tbl[14] = '{1'b0, 32'h0000_0000, 4'hF, 4'h0,    32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1};

      for (int u = 0; u < 3; u++) begin
         ia[u] = 32'h0; irm[u] = 4'h0; da[u] = 32'h0; drm[u] = 4'h0; dwm[u] = 4'h0; dwd[u] = 32'h0;
      end
      u_a.mem[0] = 32'hDEAD_BEEF;
      u_a.mem[2] = 32'h1122_3344;
      u_a.mem[3] = 32'hCAFE_F00D;
      u_a.mem[8] = 32'h0BAD_F00D;

      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         chk("reset_imem_resp", {31'h0, irs[u]}, 32'h0);
         chk("reset_dmem_resp", {31'h0, drs[u]}, 32'h0);
         chk("reset_imem_rdata", ird[u], 32'h0);
         chk("reset_dmem_rdata", drd[u], 32'h0);
         chk("reset_err", {31'h0, er[u]}, 32'h0);
      end
      rst = 1'b1;

      // Back-to-back imem request held constantly: a pulse every second cycle.
      @(negedge clk);
      ia[0] = 32'h0; irm[0] = 4'hF;
      @(posedge clk);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("imem_resp_cadence", {31'h0, irs[0]}, {31'h0, (k % 2) == 0});
         if ((k % 2) == 0) chk("imem_rdata_held_req", ird[0], 32'hDEAD_BEEF);
      end
      irm[0] = 4'h0;

      for (int i = 0; i < 15; i++) begin
         if (tbl[i].pre_rst) begin
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            chk("midrun_reset_err", {31'h0, er[0]}, 32'h0);
            chk("midrun_reset_imem_rdata", ird[0], 32'h0);
         end
         dmem_txn(0, tbl[i].addr, tbl[i].rm, tbl[i].wm, tbl[i].wd, 2, rd, e);
         if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
         chk($sformatf("vec%0d_err", i), {31'h0, e}, {31'h0, tbl[i].exp_err});
      end

      // Same-cycle collision on index 5 with both latencies 1.
      u_b.mem[5] = 32'h0;
      u_b.mem[6] = 32'h0;
      @(negedge clk);
      ia[1] = 32'h114; irm[1] = 4'hF;
      da[1] = 32'h114; dwm[1] = 4'hF; dwd[1] = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      chk("collide_imem_resp", {31'h0, irs[1]}, 32'h1);
      chk("collide_dmem_resp", {31'h0, drs[1]}, 32'h1);
      chk("collide_imem_rdata", ird[1], 32'h0);
      irm[1] = 4'h0; dwm[1] = 4'h0;
      @(negedge clk);
      irm[1] = 4'hF;
      @(posedge clk);
      @(negedge clk);
      chk("collide_followup_resp", {31'h0, irs[1]}, 32'h1);
      chk("collide_followup_rdata", ird[1], 32'hFFFF_FFFF);
      irm[1] = 4'h0;

      // imem entering RESP on the edge the write commits sees the new word.
      @(negedge clk);
      da[1] = 32'h118; dwm[1] = 4'hF; dwd[1] = 32'h600D_CAFE;
      @(posedge clk);
      @(negedge clk);
      dwm[1] = 4'h0;
      chk("fwd_dmem_resp", {31'h0, drs[1]}, 32'h1);
      ia[1] = 32'h118; irm[1] = 4'hF;
      @(posedge clk);
      @(negedge clk);
      irm[1] = 4'h0;
      chk("fwd_imem_resp", {31'h0, irs[1]}, 32'h1);
      chk("fwd_imem_rdata", ird[1], 32'h600D_CAFE);
      chk("fwd_mem6", u_b.mem[6], 32'h600D_CAFE);
      chk("collide_err", {31'h0, er[1]}, 32'h0);

      // Reset one cycle after accepting a write with DLATENCY=3.
      u_c.mem[3] = 32'h3333_3333;
      @(negedge clk);
      da[2] = 32'h10C; dwm[2] = 4'hF; dwd[2] = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      dwm[2] = 4'h0;
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (drs[2]) seen = 1'b1;
      end
      chk("abort_no_resp", {31'h0, seen}, 32'h0);
      chk("abort_mem_unchanged", u_c.mem[3], 32'h3333_3333);
      chk("abort_dmem_rdata", drd[2], 32'h0);
      chk("abort_imem_rdata", ird[2], 32'h0);
      chk("abort_err", {31'h0, er[2]}, 32'h0);
      rst = 1'b1;
      dmem_txn(2, 32'h10C, 4'hF, 4'h0, 32'h0, 3, rd, e);
      chk("post_reset_read", rd, 32'h3333_3333);
      chk("post_reset_err", {31'h0, e}, 32'h0);
      chk("post_reset_mem", u_c.mem[3], 32'h3333_3333);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
